load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-addressed data memory.
//  Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW byte-address requests into full-word memory accesses.
//  Sub-word stores are read-merge-write in one cycle, using the memory's combinational read.
//  Accesses crossing a word boundary are split into two cycles and stall the pipeline via req_ready.
// PARAMETERS
//  MEM_WORDS  256  data memory depth in 32-bit words; word index >= MEM_WORDS is out of range
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present from EX/MEM; held stable by upstream until accepted
//  req_ready   out  1   unit can accept a request this cycle
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low 8/16/32 bits used
//  resp_valid  out  1   one-cycle pulse: request completed
//  resp_err    out  1   qualified by resp_valid: out-of-range or illegal funct3
//  resp_rdata  out  32  load result, sign/zero-extended; holds until next load completes
//  dmem_we     out  1   data memory write enable
//  dmem_a      out  32  data memory word index = {2'b00, byte_addr[31:2]}
//  dmem_wd     out  32  data memory write word (merged)
//  dmem_rd     in   32  data memory combinational read of mem[dmem_a]
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
//  Reset also forces dmem_we=0 in the same cycle.
//  Byte lanes are little-endian: byte k is bits [8k+7:8k]. off=addr[1:0]; size=1/2/4 bytes.
//  Crossing access is off+size>4: LH off 3; LW off 1..3. LB never crosses.
//  Non-crossing misaligned accesses complete in one cycle.
//  FSM states:
//   IDLE: req_ready=1. Request is accepted when req_valid=1. Word index w=addr[31:2].
//     dmem_a, dmem_wd and dmem_we are driven combinationally from req_* and dmem_rd.
//     Error (funct3 illegal, w>=MEM_WORDS, or crossing with w+1>=MEM_WORDS):
//       dmem_we=0; next cycle resp_valid=1, resp_err=1, resp_rdata=0; stay IDLE.
//     Non-crossing store: dmem_we=1, dmem_wd=dmem_rd with bytes off..off+size-1 replaced.
//       Next cycle resp_valid=1.
//     Non-crossing load: extract bytes from dmem_rd and extend per funct3.
//       Register into resp_rdata; resp_valid=1 next cycle (latency 1).
//     Crossing: first handle bytes off..3 of word w (store: merged write; load: save to hold reg).
//       Latch addr, funct3, wdata and we. Go to SECOND.
//   SECOND: req_ready=0; req_valid is ignored. dmem_a=w+1.
//     Handle bytes 0..off+size-5 of word w+1: store writes merged word; load combines with hold reg.
//     Next cycle: resp_valid=1, resp_err=0, go to IDLE (latency 2).
//  Widths: w+1 is computed in 30 bits. The out-of-range check precedes any write, so wrap never occurs.
//  resp_valid is never asserted for two consecutive cycles from one request.
//  Back-to-back single-cycle requests give one resp_valid per cycle.
//  rst in SECOND: abort. No second-word write; first-word write stays committed.
//    No resp_valid; IDLE next cycle.
//  Loads never write memory. dmem_we=0 whenever no store is being executed.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> mem[4]=0xDEADBEEF; resp_rdata=0xDEADBEEF one cycle after accept.
//  2. SB 0x7F @0x11 over 1, then LB @0x13 -> mem[4]=0xDEAD7FEF; rdata 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
//  3. SW 0x11223344 @0x0E, mem[3]=mem[4]=0 -> req_ready low 1 cycle; mem[3]=0x33440000, mem[4]=0x00001122.
//     Then LW @0x0E -> 0x11223344 after 2 cycles.
//  4. LW @0x400 and SH @0x3FF -> resp_err=1, rdata 0, dmem_we never 1, req_ready stays 1.
//  5. SW @0x0D with rst high in SECOND -> only mem[3] modified, no resp_valid, req_ready=1 next cycle.
//  6. funct3=011 store @0x20 -> resp_err=1, mem[8] unchanged; LH @0x21 (non-crossing) -> 1-cycle completion.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte-addressed RISC-V loads/stores into word accesses,
// splitting word-crossing accesses over two cycles.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        dmem_we,
    output logic [31:0] dmem_a,
    output logic [31:0] dmem_wd,
    input  logic [31:0] dmem_rd
);

    localparam int unsigned WIDX_W = 30;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t              state;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;
    logic [2:0]          lat_funct3;
    logic                lat_we;
    logic [31:0]         hold;

    logic [31:0]         cur_addr;
    logic [31:0]         cur_wdata;
    logic [2:0]          cur_funct3;
    logic [1:0]          off;
    logic [WIDX_W-1:0]   w;
    logic [WIDX_W-1:0]   w_next;
    logic [3:0]          lanes;
    logic [7:0]          bmask;
    logic                crossing;
    logic                illegal;
    logic                out_of_range;
    logic                req_err;
    logic [63:0]         wdata_sh;
    logic [63:0]         load64;
    logic [31:0]         load_raw;
    logic [31:0]         load_ext;
    logic [31:0]         store_word;

    // Replace the byte lanes selected by m with the new data.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'h0, raw[7:0]};
            3'b101:  r = {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // In SECOND the request fields come from the latched copy, not the (ignored) inputs.
    assign cur_addr   = (state == SECOND) ? lat_addr   : req_addr;
    assign cur_wdata  = (state == SECOND) ? lat_wdata  : req_wdata;
    assign cur_funct3 = (state == SECOND) ? lat_funct3 : req_funct3;

    assign off    = cur_addr[1:0];
    assign w      = cur_addr[31:2];
    assign w_next = w + WIDX_W'(1);

    always_comb begin
        lanes = 4'b1111;
        case (cur_funct3[1:0])
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Byte-lane mask over the two-word window {word w+1, word w}.
    assign bmask        = 8'({4'b0000, lanes} << off);
    assign crossing     = |bmask[7:4];
    assign illegal      = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11);
    assign out_of_range = (w >= WIDX_W'(MEM_WORDS)) ||
                          (crossing && (w_next >= WIDX_W'(MEM_WORDS)));
    assign req_err      = illegal || out_of_range;

    assign wdata_sh   = 64'(cur_wdata) << {off, 3'b000};
    assign load64     = (state == SECOND) ? {dmem_rd, hold} : {32'h0, dmem_rd};
    assign load_raw   = 32'(load64 >> {off, 3'b000});
    assign load_ext   = extend(cur_funct3, load_raw);
    assign store_word = (state == SECOND) ? merge(dmem_rd, wdata_sh[63:32], bmask[7:4])
                                          : merge(dmem_rd, wdata_sh[31:0], bmask[3:0]);

    assign req_ready = (state == IDLE);
    assign dmem_a    = {2'b00, (state == SECOND) ? w_next : w};
    assign dmem_wd   = store_word;
    // Reset in SECOND suppresses the second-word write.
    assign dmem_we   = !rst && ((state == SECOND) ? lat_we
                                                  : (req_valid && req_we && !req_err));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
            lat_we     <= 1'b0;
            hold       <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (crossing) begin
                            lat_addr   <= req_addr;
                            lat_wdata  <= req_wdata;
                            lat_funct3 <= req_funct3;
                            lat_we     <= req_we;
                            hold       <= dmem_rd;
                            state      <= SECOND;
                        end else begin
                            resp_valid <= 1'b1;
                            if (!req_we) resp_rdata <= load_ext;
                        end
                    end
                end
                SECOND: begin
                    resp_valid <= 1'b1;
                    if (!lat_we) resp_rdata <= load_ext;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of requests with a word memory model,
// plus hand sequences for back-to-back issue and reset during the second word.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_we;
    logic [31:0] dmem_a;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] mem [256] = '{default: 32'h0};

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .dmem_we    (dmem_we),
        .dmem_a     (dmem_a),
        .dmem_wd    (dmem_wd),
        .dmem_rd    (dmem_rd)
    );

    // Word memory with combinational read; writes and write-enable cycles counted.
    assign dmem_rd = (dmem_a < 32'd256) ? mem[dmem_a[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (dmem_we) begin
            we_cnt <= we_cnt + 1;
            if (dmem_a < 32'd256) mem[dmem_a[7:0]] <= dmem_wd;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        int          mi0;
        logic [31:0] mv0;
        int          mi1;
        logic [31:0] mv1;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int cyc, input logic err,
                       input logic [31:0] rdata, input int mi0, input logic [31:0] mv0,
                       input int mi1, input logic [31:0] mv1);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.cyc = cyc; v.err = err;
        v.rdata = rdata; v.mi0 = mi0; v.mv0 = mv0; v.mi1 = mi1; v.mv1 = mv1;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one request and wait (bounded) for its response.
    task automatic issue(input vec_t v, output int cyc, output logic err,
                         output logic [31:0] rd, output int rlow, output int wes);
        int w0;
        bit got;
        w0 = we_cnt;
        got = 0; cyc = 0; rlow = 0; err = 1'b0; rd = 32'h0;
        req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            cyc++;
            if (resp_valid) begin
                got = 1;
                err = resp_err;
                rd = resp_rdata;
            end else if (!req_ready) begin
                rlow++;
            end
        end
        if (!got) cyc = 99;
        wes = we_cnt - w0;
    endtask

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    initial begin
        int cyc, rlow, wes;
        logic err;
        logic [31:0] rd;
        string nm;

        //   we  f3      addr       wdata        cyc err rdata         mi0 mv0           mi1 mv1
        add(1, W,      32'h10,  32'hDEADBEEF, 1, 0, 32'h0,         4,  32'hDEADBEEF, -1, 32'h0);
        add(0, W,      32'h10,  32'h0,        1, 0, 32'hDEADBEEF, -1,  32'h0,        -1, 32'h0);
        add(1, B,      32'h11,  32'hAAAAAA7F, 1, 0, 32'h0,         4,  32'hDEAD7FEF, -1, 32'h0);
        add(0, B,      32'h13,  32'h0,        1, 0, 32'hFFFFFFDE, -1,  32'h0,        -1, 32'h0);
        add(0, BU,     32'h13,  32'h0,        1, 0, 32'h000000DE, -1,  32'h0,        -1, 32'h0);
        add(1, W,      32'h10,  32'h0,        1, 0, 32'h0,         4,  32'h0,        -1, 32'h0);
        add(1, W,      32'h0E,  32'h11223344, 2, 0, 32'h0,         3,  32'h33440000,  4, 32'h00001122);
        add(0, W,      32'h0E,  32'h0,        2, 0, 32'h11223344, -1,  32'h0,        -1, 32'h0);
        add(0, W,      32'h400, 32'h0,        1, 1, 32'h0,        -1,  32'h0,        -1, 32'h0);
        add(1, H,      32'h3FF, 32'h0000BEEF, 1, 1, 32'h0,       255,  32'h0,        -1, 32'h0);
        add(1, W,      32'h20,  32'hCAFEF00D, 1, 0, 32'h0,         8,  32'hCAFEF00D, -1, 32'h0);
        add(1, 3'b011, 32'h20,  32'hFFFFFFFF, 1, 1, 32'h0,         8,  32'hCAFEF00D, -1, 32'h0);
        add(0, H,      32'h21,  32'h0,        1, 0, 32'hFFFFFEF0, -1,  32'h0,        -1, 32'h0);
        add(0, HU,     32'h21,  32'h0,        1, 0, 32'h0000FEF0, -1,  32'h0,        -1, 32'h0);
        add(0, H,      32'h23,  32'h0,        2, 0, 32'h000000CA, -1,  32'h0,        -1, 32'h0);
        add(1, H,      32'h27,  32'h1234BEEF, 2, 0, 32'h0,         9,  32'hEF000000, 10, 32'h000000BE);
        add(0, H,      32'h27,  32'h0,        2, 0, 32'hFFFFBEEF, -1,  32'h0,        -1, 32'h0);
        add(0, HU,     32'h27,  32'h0,        2, 0, 32'h0000BEEF, -1,  32'h0,        -1, 32'h0);
        add(0, B,      32'h27,  32'h0,        1, 0, 32'hFFFFFFEF, -1,  32'h0,        -1, 32'h0);
        add(0, W,      32'h26,  32'h0,        2, 0, 32'h00BEEF00, -1,  32'h0,        -1, 32'h0);
        add(0, W,      32'h3FD, 32'h0,        1, 1, 32'h0,        -1,  32'h0,        -1, 32'h0);
        add(1, B,      32'h3FF, 32'h0000005A, 1, 0, 32'h0,       255,  32'h5A000000, -1, 32'h0);
        add(0, W,      32'h3FC, 32'h0,        1, 0, 32'h5A000000, -1,  32'h0,        -1, 32'h0);
        add(0, 3'b110, 32'h10,  32'h0,        1, 1, 32'h0,        -1,  32'h0,        -1, 32'h0);

        // Reset with a live store request: no write, outputs at reset values.
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = W;
        req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_mem4", mem[4], 32'h0);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            issue(vt[i], cyc, err, rd, rlow, wes);
            nm = $sformatf("v%0d", i);
            chk({nm, "_cycles"}, 32'(cyc), 32'(vt[i].cyc));
            chk({nm, "_err"}, 32'(err), 32'(vt[i].err));
            chk({nm, "_ready_low"}, 32'(rlow), 32'(vt[i].cyc - 1));
            chk({nm, "_we_cycles"}, 32'(wes),
                (vt[i].we && !vt[i].err) ? 32'(vt[i].cyc) : 32'd0);
            if (!vt[i].we || vt[i].err) chk({nm, "_rdata"}, rd, vt[i].rdata);
            if (vt[i].mi0 >= 0) chk({nm, "_mem0"}, mem[vt[i].mi0], vt[i].mv0);
            if (vt[i].mi1 >= 0) chk({nm, "_mem1"}, mem[vt[i].mi1], vt[i].mv1);
        end

        // Back-to-back loads: one response per cycle, then quiet.
        req_we = 1'b0; req_funct3 = W; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_valid", 32'(resp_valid), 32'd1);
        chk("b2b_first_rdata", resp_rdata, 32'h00001122);
        req_addr = 32'h20;
        @(posedge clk); #1;
        chk("b2b_second_valid", 32'(resp_valid), 32'd1);
        chk("b2b_second_rdata", resp_rdata, 32'hCAFEF00D);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_valid", 32'(resp_valid), 32'd0);

        // Crossing store aborted by reset in SECOND.
        req_we = 1'b1; req_funct3 = W; req_addr = 32'h0D; req_wdata = 32'hA1B2C3D4;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_second", 32'(req_ready), 32'd0);
        chk("abort_valid_second", 32'(resp_valid), 32'd0);
        req_valid = 1'b0; rst = 1'b1;
        #1;
        chk("abort_dmem_we", 32'(dmem_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid_after", 32'(resp_valid), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_mem3", mem[3], 32'hB2C3D400);
        chk("abort_mem4", mem[4], 32'h00001122);
        @(posedge clk); #1;
        chk("abort_valid_later", 32'(resp_valid), 32'd0);
        chk("abort_mem4_later", mem[4], 32'h00001122);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
